score_overlay: RTL and testbench

- Sits directly upstream of the digit sprite ROMs (11x16 px, 3-bit rgb, combinational row/col lookup, 000 outside the sprite).
- Holds both players' scores and tracks game state (play / game over).
- For every VGA pixel, generates sprite-relative row/col and the digit value for an external 0..9 ROM mux.
- Registers the returned sprite rgb as the score layer feeding the Pong pixel compositor.

---
 rtl/score_overlay.sv | 216 +++++++++++++++++++++
 tb/tb_score_overlay.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/score_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : score_overlay
//  Description : Holds both players' scores and the play / game-over state,
//                and renders the two score digits as a 3-bit rgb layer.
//                For every VGA pixel it produces sprite-relative row/col and
//                the digit value for an external 0..9 sprite ROM mux. It then
//                registers the rgb value that mux returns.
//  Ports       : clk, reset_n         - pixel clock, async active-low reset
//                point_p1/p2, new_game - one-cycle game event pulses
//                pixel_row/col/valid  - current VGA pixel
//                digit_row/col/value  - registered lookup to the ROM mux
//                digit_rgb            - combinational ROM mux return
//                rgb, rgb_valid       - score-layer pixel, 2 clocks latency
//                score_p1/p2, game_over, winner - game status
//  Revision    : 1.0 - initial release
// ============================================================================
module score_overlay #(
    parameter int DIGIT_W      = 11,
    parameter int DIGIT_H      = 16,
    parameter int P1_X         = 280,
    parameter int P2_X         = 349,
    parameter int SCORE_Y      = 16,
    parameter int WIN_SCORE    = 9,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       point_p1,
    input  logic       point_p2,
    input  logic       new_game,
    input  logic [9:0] pixel_row,
    input  logic [9:0] pixel_col,
    input  logic       pixel_valid,
    output logic [9:0] digit_row,
    output logic [9:0] digit_col,
    output logic [3:0] digit_value,
    input  logic [2:0] digit_rgb,
    output logic [2:0] rgb,
    output logic       rgb_valid,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic       game_over,
    output logic       winner
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [9:0]       c_p1_x       = 10'(P1_X);
    localparam logic [9:0]       c_p1_x_end   = 10'(P1_X + DIGIT_W);
    localparam logic [9:0]       c_p2_x       = 10'(P2_X);
    localparam logic [9:0]       c_p2_x_end   = 10'(P2_X + DIGIT_W);
    localparam logic [9:0]       c_score_y    = 10'(SCORE_Y);
    localparam logic [9:0]       c_row_end    = 10'(SCORE_Y + DIGIT_H);
    localparam logic [9:0]       c_no_hit     = 10'h3FF;
    localparam logic [3:0]       c_win        = 4'(WIN_SCORE);
    localparam logic [CNT_W-1:0] c_blink_last = CNT_W'(BLINK_FRAMES - 1);

    typedef enum logic [0:0] {
        ST_PLAY = 1'b0,
        ST_OVER = 1'b1
    } state_t;

    state_t            r_state;
    logic [3:0]        r_score_p1;
    logic [3:0]        r_score_p2;
    logic              r_winner;
    logic [CNT_W-1:0]  r_blink_cnt;
    logic              r_blink_phase;   // 1 = winner digit visible

    logic [9:0]        r_digit_row;
    logic [9:0]        r_digit_col;
    logic [3:0]        r_digit_value;
    logic              r_hit_s1;
    logic              r_valid_s1;
    logic [2:0]        r_rgb;
    logic              r_rgb_valid;

    state_t            w_state_nxt;
    logic [3:0]        w_score_p1_nxt;
    logic [3:0]        w_score_p2_nxt;
    logic              w_winner_nxt;
    logic [CNT_W-1:0]  w_blink_cnt_nxt;
    logic              w_blink_phase_nxt;

    logic              w_tick;
    logic [3:0]        w_p1_inc;
    logic [3:0]        w_p2_inc;
    logic              w_row_in;
    logic              w_hit1;
    logic              w_hit2;
    logic              w_hide_p1;
    logic              w_hide_p2;

    assign w_tick   = pixel_valid && (pixel_row == 10'd0) && (pixel_col == 10'd0);
    assign w_p1_inc = r_score_p1 + 4'd1;
    assign w_p2_inc = r_score_p2 + 4'd1;

    // Next game state. Computed combinationally so the pixel stage can show
    // the score produced by the same clock edge.
    always_comb begin
        w_state_nxt       = r_state;
        w_score_p1_nxt    = r_score_p1;
        w_score_p2_nxt    = r_score_p2;
        w_winner_nxt      = r_winner;
        w_blink_cnt_nxt   = r_blink_cnt;
        w_blink_phase_nxt = r_blink_phase;

        if (new_game) begin
            w_state_nxt       = ST_PLAY;
            w_score_p1_nxt    = 4'd0;
            w_score_p2_nxt    = 4'd0;
            w_winner_nxt      = 1'b0;
            w_blink_cnt_nxt   = '0;
            w_blink_phase_nxt = 1'b1;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    w_blink_cnt_nxt   = '0;
                    w_blink_phase_nxt = 1'b1;
                    // Simultaneous points cancel out: neither is counted.
                    if (point_p1 && !point_p2) begin
                        w_score_p1_nxt = w_p1_inc;
                        if (w_p1_inc == c_win) begin
                            w_state_nxt  = ST_OVER;
                            w_winner_nxt = 1'b0;
                        end
                    end else if (point_p2 && !point_p1) begin
                        w_score_p2_nxt = w_p2_inc;
                        if (w_p2_inc == c_win) begin
                            w_state_nxt  = ST_OVER;
                            w_winner_nxt = 1'b1;
                        end
                    end
                end
                ST_OVER: begin
                    if (w_tick) begin
                        if (r_blink_cnt == c_blink_last) begin
                            w_blink_cnt_nxt   = '0;
                            w_blink_phase_nxt = !r_blink_phase;
                        end else begin
                            w_blink_cnt_nxt = r_blink_cnt + CNT_W'(1);
                        end
                    end
                end
                default: w_state_nxt = ST_PLAY;
            endcase
        end
    end

    // Window hit tests; the two windows never overlap.
    assign w_row_in = (pixel_row >= c_score_y) && (pixel_row < c_row_end);
    assign w_hit1   = pixel_valid && w_row_in && (pixel_col >= c_p1_x) && (pixel_col < c_p1_x_end);
    assign w_hit2   = pixel_valid && w_row_in && (pixel_col >= c_p2_x) && (pixel_col < c_p2_x_end);

    // The winner's digit is blanked during the off half of the blink.
    assign w_hide_p1 = (w_state_nxt == ST_OVER) && !w_blink_phase_nxt && !w_winner_nxt;
    assign w_hide_p2 = (w_state_nxt == ST_OVER) && !w_blink_phase_nxt &&  w_winner_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_PLAY;
            r_score_p1    <= 4'd0;
            r_score_p2    <= 4'd0;
            r_winner      <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
            r_digit_row   <= c_no_hit;
            r_digit_col   <= c_no_hit;
            r_digit_value <= 4'd0;
            r_hit_s1      <= 1'b0;
            r_valid_s1    <= 1'b0;
            r_rgb         <= 3'b000;
            r_rgb_valid   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_score_p1    <= w_score_p1_nxt;
            r_score_p2    <= w_score_p2_nxt;
            r_winner      <= w_winner_nxt;
            r_blink_cnt   <= w_blink_cnt_nxt;
            r_blink_phase <= w_blink_phase_nxt;

            // Stage 1: sprite-relative lookup address
            if (w_hit1) begin
                r_digit_row   <= pixel_row - c_score_y;
                r_digit_col   <= pixel_col - c_p1_x;
                r_digit_value <= w_score_p1_nxt;
            end else if (w_hit2) begin
                r_digit_row   <= pixel_row - c_score_y;
                r_digit_col   <= pixel_col - c_p2_x;
                r_digit_value <= w_score_p2_nxt;
            end else begin
                r_digit_row   <= c_no_hit;
                r_digit_col   <= c_no_hit;
            end
            r_hit_s1   <= (w_hit1 && !w_hide_p1) || (w_hit2 && !w_hide_p2);
            r_valid_s1 <= pixel_valid;

            // Stage 2: capture the ROM mux return
            r_rgb       <= r_hit_s1 ? digit_rgb : 3'b000;
            r_rgb_valid <= r_valid_s1;
        end
    end

    assign digit_row   = r_digit_row;
    assign digit_col   = r_digit_col;
    assign digit_value = r_digit_value;
    assign rgb         = r_rgb;
    assign rgb_valid   = r_rgb_valid;
    assign score_p1    = r_score_p1;
    assign score_p2    = r_score_p2;
    assign game_over   = (r_state == ST_OVER);
    assign winner      = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_score_overlay.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_overlay
//  Description : Self-checking bench for score_overlay. A behavioural sprite
//                ROM answers the DUT lookup; expected pixels are computed from
//                a game model and queued, then popped when the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_overlay;

    localparam int DIGIT_W      = 11;
    localparam int DIGIT_H      = 16;
    localparam int P1_X         = 280;
    localparam int P2_X         = 349;
    localparam int SCORE_Y      = 16;
    localparam int WIN_SCORE    = 9;
    localparam int BLINK_FRAMES = 30;

    logic       clk;
    logic       reset_n;
    logic       point_p1, point_p2, new_game;
    logic [9:0] pixel_row, pixel_col;
    logic       pixel_valid;
    logic [9:0] digit_row, digit_col;
    logic [3:0] digit_value;
    logic [2:0] digit_rgb;
    logic [2:0] rgb;
    logic       rgb_valid;
    logic [3:0] score_p1, score_p2;
    logic       game_over, winner;

    typedef struct {
        logic [2:0] rgb;
        logic       vld;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Game model
    int m_s1, m_s2, m_cnt;
    bit m_over, m_winner, m_phase;

    score_overlay #(
        .DIGIT_W(DIGIT_W), .DIGIT_H(DIGIT_H), .P1_X(P1_X), .P2_X(P2_X),
        .SCORE_Y(SCORE_Y), .WIN_SCORE(WIN_SCORE), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .point_p1(point_p1), .point_p2(point_p2), .new_game(new_game),
        .pixel_row(pixel_row), .pixel_col(pixel_col), .pixel_valid(pixel_valid),
        .digit_row(digit_row), .digit_col(digit_col), .digit_value(digit_value),
        .digit_rgb(digit_rgb), .rgb(rgb), .rgb_valid(rgb_valid),
        .score_p1(score_p1), .score_p2(score_p2),
        .game_over(game_over), .winner(winner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sprite ROM stand-in: every in-sprite pixel is non-black and depends on
    // value, row and column; 000 outside the sprite.
    function automatic logic [2:0] rom(input int v, input int r, input int c);
        if (r >= 0 && r < DIGIT_H && c >= 0 && c < DIGIT_W)
            return 3'(((v + r + c) % 7) + 1);
        return 3'b000;
    endfunction

    assign digit_rgb = rom(int'(digit_value), int'(digit_row), int'(digit_col));

    function automatic logic [2:0] exp_rgb(input int r, input int c, input bit v);
        bit rin, h1, h2;
        rin = (r >= SCORE_Y) && (r < SCORE_Y + DIGIT_H);
        h1  = v && rin && (c >= P1_X) && (c < P1_X + DIGIT_W);
        h2  = v && rin && (c >= P2_X) && (c < P2_X + DIGIT_W);
        if (h1 && !(m_over && !m_phase && !m_winner)) return rom(m_s1, r - SCORE_Y, c - P1_X);
        if (h2 && !(m_over && !m_phase &&  m_winner)) return rom(m_s2, r - SCORE_Y, c - P2_X);
        return 3'b000;
    endfunction

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_cnt = 0;
        m_over = 1'b0; m_winner = 1'b0; m_phase = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        pixel_valid = 1'b0; pixel_row = 10'd0; pixel_col = 10'd0;
    endtask

    task automatic drive_pixel(input int r, input int c, input bit v);
        exp_t e;
        @(negedge clk);
        pixel_row = 10'(r); pixel_col = 10'(c); pixel_valid = v;
        e.rgb = exp_rgb(r, c, v);
        e.vld = v;
        sb.push_back(e);
    endtask

    task automatic pulse(input bit p1, input bit p2, input bit ng);
        @(negedge clk);
        point_p1 = p1; point_p2 = p2; new_game = ng;
        @(negedge clk);
        point_p1 = 1'b0; point_p2 = 1'b0; new_game = 1'b0;
        if (ng) begin
            model_reset();
        end else if (!m_over) begin
            if (p1 && !p2) begin
                m_s1++;
                if (m_s1 == WIN_SCORE) begin m_over = 1'b1; m_winner = 1'b0; end
            end else if (p2 && !p1) begin
                m_s2++;
                if (m_s2 == WIN_SCORE) begin m_over = 1'b1; m_winner = 1'b1; end
            end
        end
    endtask

    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pixel_row = 10'd0; pixel_col = 10'd0; pixel_valid = 1'b1;
            if (m_over) begin
                if (m_cnt == BLINK_FRAMES - 1) begin m_cnt = 0; m_phase = !m_phase; end
                else m_cnt++;
            end
        end
        @(negedge clk);
        pixel_valid = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        pulse(1'b1, 1'b0, 1'b0);
        drive_pixel(20, 285, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++; if (rgb !== e.rgb) begin n_err++; $display("FAIL pre_reset_rgb: got %b want %b", rgb, e.rgb); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (rgb !== 3'b000) begin n_err++; $display("FAIL reset_rgb: got %b want 000", rgb); end
        n_cmp++; if (rgb_valid !== 1'b0) begin n_err++; $display("FAIL reset_rgb_valid: got %b want 0", rgb_valid); end
        n_cmp++; if (score_p1 !== 4'd0) begin n_err++; $display("FAIL reset_score_p1: got %0d want 0", score_p1); end
        n_cmp++; if (digit_row !== 10'h3FF) begin n_err++; $display("FAIL reset_digit_row: got %h want 3ff", digit_row); end
        n_cmp++; if (digit_col !== 10'h3FF) begin n_err++; $display("FAIL reset_digit_col: got %h want 3ff", digit_col); end
        n_cmp++; if (digit_value !== 4'd0) begin n_err++; $display("FAIL reset_digit_value: got %0d want 0", digit_value); end
        n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL reset_game_over: got %b want 0", game_over); end
        sb.delete();
        model_reset();
        idle();
        reset_n = 1'b1;
    endtask

    task automatic test_score_pixel();
        exp_t e;
        repeat (3) pulse(1'b1, 1'b0, 1'b0);
        n_cmp++; if (score_p1 !== 4'd3) begin n_err++; $display("FAIL score_p1_three: got %0d want 3", score_p1); end
        drive_pixel(20, 285, 1'b1);
        @(posedge clk); #1;
        n_cmp++; if (digit_row !== 10'd4) begin n_err++; $display("FAIL hit_digit_row: got %0d want 4", digit_row); end
        n_cmp++; if (digit_col !== 10'd5) begin n_err++; $display("FAIL hit_digit_col: got %0d want 5", digit_col); end
        n_cmp++; if (digit_value !== 4'd3) begin n_err++; $display("FAIL hit_digit_value: got %0d want 3", digit_value); end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++; if (rgb !== e.rgb) begin n_err++; $display("FAIL hit_rgb: got %b want %b", rgb, e.rgb); end
        n_cmp++; if (rgb_valid !== 1'b1) begin n_err++; $display("FAIL hit_rgb_valid: got %b want 1", rgb_valid); end
        idle();
    endtask

    task automatic test_simultaneous();
        pulse(1'b1, 1'b1, 1'b0);
        n_cmp++; if (score_p1 !== 4'(m_s1)) begin n_err++; $display("FAIL both_points_p1: got %0d want %0d", score_p1, m_s1); end
        n_cmp++; if (score_p2 !== 4'(m_s2)) begin n_err++; $display("FAIL both_points_p2: got %0d want %0d", score_p2, m_s2); end
        pulse(1'b0, 1'b1, 1'b1);
        n_cmp++; if (score_p1 !== 4'd0) begin n_err++; $display("FAIL new_game_p1: got %0d want 0", score_p1); end
        n_cmp++; if (score_p2 !== 4'd0) begin n_err++; $display("FAIL new_game_beats_p2: got %0d want 0", score_p2); end
    endtask

    task automatic test_win();
        repeat (WIN_SCORE - 1) pulse(1'b0, 1'b1, 1'b0);
        n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL not_over_at_8: got %b want 0", game_over); end
        pulse(1'b0, 1'b1, 1'b0);
        n_cmp++; if (game_over !== 1'b1) begin n_err++; $display("FAIL win_game_over: got %b want 1", game_over); end
        n_cmp++; if (winner !== 1'b1) begin n_err++; $display("FAIL win_winner: got %b want 1", winner); end
        n_cmp++; if (score_p2 !== 4'(WIN_SCORE)) begin n_err++; $display("FAIL win_score_p2: got %0d want %0d", score_p2, WIN_SCORE); end
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        n_cmp++; if (score_p1 !== 4'd0) begin n_err++; $display("FAIL over_frozen_p1: got %0d want 0", score_p1); end
        n_cmp++; if (score_p2 !== 4'(WIN_SCORE)) begin n_err++; $display("FAIL over_no_wrap_p2: got %0d want %0d", score_p2, WIN_SCORE); end
    endtask

    // Check one pixel through the scoreboard; name identifies the phase.
    task automatic test_blink();
        exp_t e;
        int   steps[4] = '{BLINK_FRAMES - 1, 1, BLINK_FRAMES - 1, 1};
        bit   want_vis[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 4; k++) begin
            frame_ticks(steps[k]);
            drive_pixel(20, P2_X + 3, 1'b1);
            @(posedge clk); @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++; if (rgb !== e.rgb) begin n_err++; $display("FAIL blink_p2_step%0d: got %b want %b", k, rgb, e.rgb); end
            n_cmp++; if ((rgb !== 3'b000) !== want_vis[k]) begin n_err++; $display("FAIL blink_p2_visible_step%0d: got %b want %b", k, rgb !== 3'b000, want_vis[k]); end
            drive_pixel(20, P1_X + 5, 1'b1);
            @(posedge clk); @(posedge clk); #1;
            e = sb.pop_front();
            n_cmp++; if (rgb !== e.rgb) begin n_err++; $display("FAIL blink_p1_step%0d: got %b want %b", k, rgb, e.rgb); end
            idle();
        end
        pulse(1'b0, 1'b0, 1'b1);
        n_cmp++; if (game_over !== 1'b0) begin n_err++; $display("FAIL new_game_clears_over: got %b want 0", game_over); end
        n_cmp++; if (winner !== 1'b0) begin n_err++; $display("FAIL new_game_clears_winner: got %b want 0", winner); end
    endtask

    task automatic test_boundaries();
        exp_t e;
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        drive_pixel(20, P1_X + 2, 1'b1);
        @(posedge clk); #1;
        drive_pixel(20, P1_X + DIGIT_W, 1'b1);
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++; if (digit_col !== 10'h3FF) begin n_err++; $display("FAIL edge_col_digit_col: got %h want 3ff", digit_col); end
        n_cmp++; if (digit_row !== 10'h3FF) begin n_err++; $display("FAIL edge_col_digit_row: got %h want 3ff", digit_row); end
        n_cmp++; if (digit_value !== 4'd2) begin n_err++; $display("FAIL miss_holds_value: got %0d want 2", digit_value); end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++; if (rgb !== e.rgb) begin n_err++; $display("FAIL edge_col_rgb: got %b want %b", rgb, e.rgb); end
        drive_pixel(20, 285, 1'b0);
        @(posedge clk); #1;
        n_cmp++; if (digit_col !== 10'h3FF) begin n_err++; $display("FAIL invalid_digit_col: got %h want 3ff", digit_col); end
        @(posedge clk); #1;
        e = sb.pop_front();
        n_cmp++; if (rgb !== 3'b000) begin n_err++; $display("FAIL invalid_rgb: got %b want 000", rgb); end
        n_cmp++; if (rgb_valid !== 1'b0) begin n_err++; $display("FAIL invalid_rgb_valid: got %b want 0", rgb_valid); end
        idle();
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   rows[3] = '{SCORE_Y, SCORE_Y + DIGIT_H - 1, SCORE_Y + DIGIT_H};
        int   n;
        n = P2_X + DIGIT_W + 2 - (P1_X - 2);
        sb.delete();
        for (int ri = 0; ri < 3; ri++) begin
            for (int i = 0; i <= n; i++) begin
                if (i < n) drive_pixel(rows[ri], P1_X - 2 + i, 1'b1);
                else       drive_pixel(rows[ri], 0, 1'b0);
                @(posedge clk); #1;
                if (i >= 1) begin
                    e = sb.pop_front();
                    n_cmp++; if (rgb !== e.rgb || rgb_valid !== e.vld) begin
                        n_err++;
                        $display("FAIL stream_row%0d_col%0d: got %b/%b want %b/%b",
                                 rows[ri], P1_X - 3 + i, rgb, rgb_valid, e.rgb, e.vld);
                    end
                end
            end
            sb.delete();
        end
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        point_p1 = 1'b0; point_p2 = 1'b0; new_game = 1'b0;
        pixel_row = 10'd0; pixel_col = 10'd0; pixel_valid = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        test_reset();
        test_score_pixel();
        test_simultaneous();
        test_win();
        test_blink();
        test_boundaries();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
